serial_subst_ctrl: RTL and testbench
====================================

// Module: serial_subst_ctrl
// PURPOSE
//   Bit-serial multi-bit subtractor controller. Computes DIFF = A - B by sequencing
//   one 1-bit subtractor cell over WIDTH clock cycles, LSB first. A registered borrow
//   is carried between bits. Sits between a start/done requester and the 1-bit
//   subtract datapath, so one cell is time-shared across all bit positions.
// PARAMETERS
//   WIDTH    8   operand/result width in bits; legal range 2..32
//   CNT_W    $clog2(WIDTH)+1   bit-counter width (derived; do not override)
// PORTS
//   clk         in   1      single system clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request: latch a/b and begin; honoured only in IDLE
//   a           in   WIDTH  minuend, sampled on the accepted start edge only
//   b           in   WIDTH  subtrahend, sampled on the accepted start edge only
//   busy        out  1      high in RUN and DONE; start is ignored while high
//   done        out  1      one-cycle pulse; diff/borrow_out/zero valid
//   diff        out  WIDTH  A - B modulo 2^WIDTH; held until the next accepted start
//   borrow_out  out  1      final borrow; 1 means A < B unsigned
//   zero        out  1      1 when diff == 0; valid with done, then held
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy, done, diff, borrow_out, zero, the
//     internal shift registers, borrow FF and counter are all 0. Takes effect
//     immediately, including mid-RUN. Release is synchronous to the next clk edge.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge k latches a->sa and b->sb, and clears borrow and cnt.
//     State moves to RUN. start=0 keeps the FSM in IDLE.
//   - RUN, one bit per edge:
//       d  = sa[0] ^ sb[0] ^ borrow
//       bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)
//     Each edge: sa and sb shift right, d shifts into the MSB of diff_sr,
//     borrow<=bo, cnt<=cnt+1.
//     When cnt==WIDTH-1 at an edge, that edge processes the last bit and the
//     state moves to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//     diff, borrow_out and zero update at the edge entering DONE (edge k+WIDTH).
//     done is therefore high in the cycle after edge k+WIDTH: latency is WIDTH edges.
//   - start while busy (RUN or DONE) is ignored, with no queuing. a/b changes after
//     the start edge have no effect.
//   - Back-to-back: start held high continuously is accepted every WIDTH+2 edges
//     (RUN x WIDTH, DONE x 1, IDLE x 1).
//   - Outputs hold their last result through IDLE. They change only at the next
//     DONE entry or at reset.
//   - Arithmetic: unsigned two's-complement wrap. No saturation, no overflow flag.
//   - Counter never exceeds WIDTH-1. An illegal state encoding returns to IDLE.
// STRUCTURE
//   - Shared package: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1,
//     S_DONE=2'd2) and the WIDTH default constant.
//   - One sub-module, sub_bit_cell: combinational 1-bit full subtractor
//     (inputs x, y, bin; outputs d, bout), built from two half-subtractor stages
//     plus an OR.
//   - Top level contains only the FSM, counter, shift registers and borrow FF.
// TESTING
//   1. WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> done 8 edges later; diff=8'h1E,
//      borrow_out=0, zero=0.
//   2. a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1, zero=0.
//   3. a=b=8'hA5 -> diff=8'h00, zero=1, borrow_out=0.
//   4. During RUN, pulse start with a=8'hFF, b=8'h00 -> ignored; the first result
//      is unchanged and exactly one done pulse occurs.
//   5. Drop rst_n at RUN cycle 4 -> busy=0, diff=0 immediately. After release,
//      start with a=8'h10, b=8'h01 -> diff=8'h0F.
//   6. start held high for 3 operations -> done pulses spaced 10 edges apart, with
//      correct diff for each operand pair; outputs stable between pulses.

Source files
------------

// File: rtl/serial_subst_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
//   WIDTH_DEF : default operand/result width
//   state_t   : controller state encoding
package serial_subst_ctrl_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subst_ctrl_sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
// Built from two half-subtractor stages whose borrows are ORed.
//   x, y, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module sub_bit_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   assign d1   = x ^ y;
   assign b1   = ~x & y;
   assign d    = d1 ^ bin;
   assign b2   = ~d1 & bin;
   assign bout = b1 | b2;

endmodule

// File: rtl/serial_subst_ctrl.sv
// Bit-serial subtractor controller: DIFF = A - B, one bit per clock, LSB first,
// time-sharing a single sub_bit_cell.
//   clk, rst_n   : clock, async active-low reset
//   start        : begin an operation (accepted only in IDLE); latches a, b
//   a, b         : minuend, subtrahend
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse when results are valid
//   diff         : A - B modulo 2^WIDTH, held until the next result
//   borrow_out   : final borrow (A < B unsigned)
//   zero         : diff == 0
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | processing one bit per edge, WIDTH edges
// S_DONE | results valid, done pulse
module serial_subst_ctrl
   import serial_subst_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] diff_sr;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;
   logic [WIDTH-1:0] diff_nxt;

   sub_bit_cell u_cell (
      .x    (sa[0]),
      .y    (sb[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // The partial result keeps only the upper WIDTH-1 bits; the final bit
   // completes the word directly into diff.
   assign diff_nxt = {cell_d, diff_sr};
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_bit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa         <= '0;
         sb         <= '0;
         diff_sr    <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  borrow <= 1'b0;
                  cnt    <= '0;
               end
            end
            S_RUN: begin
               sa      <= sa >> 1;
               sb      <= sb >> 1;
               diff_sr <= diff_nxt[WIDTH-1:1];
               borrow  <= cell_bout;
               if (last_bit) begin
                  // Counter parks at 0 rather than stepping past WIDTH-1.
                  cnt        <= '0;
                  diff       <= diff_nxt;
                  borrow_out <= cell_bout;
                  zero       <= (diff_nxt == '0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subst_ctrl.sv
module tb_serial_subst_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         zero;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   serial_subst_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted operation finishes W edges later with the
   // plain arithmetic result, then shows done for one cycle.
   int           m_rem = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   logic [W-1:0] m_diff = '0;
   logic         m_bo = 1'b0;
   logic         m_zero = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_diff <= '0;
         m_bo   <= 1'b0;
         m_zero <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_rem > 1) begin
         m_rem <= m_rem - 1;
      end else if (m_rem == 1) begin
         m_rem  <= 0;
         m_done <= 1'b1;
         m_diff <= m_a - m_b;
         m_bo   <= (m_a < m_b);
         m_zero <= (m_a == m_b);
      end else if (start) begin
         m_a   <= a;
         m_b   <= b;
         m_rem <= W;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 32'(busy), 32'(m_rem > 0 || m_done));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_diff", 32'(diff), 32'(m_diff));
         check("cyc_borrow", 32'(borrow_out), 32'(m_bo));
         check("cyc_zero", 32'(zero), 32'(m_zero));
      end
   end

   // Pulse start for one cycle, wait for done, check latency and literal results.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ediff, input logic ebo, input logic ez);
      int j;
      @(negedge clk);
      a = ta;
      b = tb_;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      j = 0;
      while (done !== 1'b1 && j < 30) begin
         @(negedge clk);
         j++;
      end
      check("latency", 32'(j), 32'(W));
      check("lit_diff", 32'(diff), 32'(ediff));
      check("lit_borrow", 32'(borrow_out), 32'(ebo));
      check("lit_zero", 32'(zero), 32'(ez));
   endtask

   initial begin
      int n_done;
      int t_prev;
      int t_cur;
      int j;
      logic [W-1:0] pa [3];
      logic [W-1:0] pb [3];
      logic [W-1:0] pd [3];

      #3 rst_n = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      rst_n = 1'b1;

      // Basic operations.
      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1);

      // start during RUN is ignored: one done pulse, first result kept.
      @(negedge clk);
      a = 8'h5A;
      b = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("ignored_start_pulses", 32'(n_done), 32'd1);
      check("ignored_start_diff", 32'(diff), 32'h1E);

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      a = 8'h5A;
      b = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_diff", 32'(diff), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

      // start held high: three back-to-back operations.
      pa[0] = 8'h33; pb[0] = 8'h11; pd[0] = 8'h22;
      pa[1] = 8'h10; pb[1] = 8'h20; pd[1] = 8'hF0;
      pa[2] = 8'h77; pb[2] = 8'h77; pd[2] = 8'h00;
      @(negedge clk);
      a = pa[0];
      b = pb[0];
      start = 1'b1;
      t_prev = 0;
      t_cur = 0;
      for (int k = 0; k < 3; k++) begin
         j = 0;
         while (done !== 1'b1 && j < 30) begin
            @(negedge clk);
            t_cur++;
            j++;
         end
         check("b2b_found", 32'(done), 32'd1);
         check("b2b_diff", 32'(diff), 32'(pd[k]));
         if (k > 0) check("b2b_spacing", 32'(t_cur - t_prev), 32'(W + 2));
         t_prev = t_cur;
         if (k < 2) begin
            a = pa[k+1];
            b = pb[k+1];
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         t_cur++;
      end
      check("b2b_borrow_last", 32'(borrow_out), 32'd0);
      check("b2b_zero_last", 32'(zero), 32'd1);
      repeat (12) @(negedge clk);
      check("idle_after_b2b", 32'(busy), 32'd0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
